// File: rtl/aes_cmd_pkg.sv
// aes_cmd_pkg: shared definitions for the AES command master.
//   - Opcode constants accepted in the host header word.
//   - Controller state enumeration.
//   - Error codes returned as single-word responses.
//   - Payload word counts and small helpers for packing/unpacking.
package aes_cmd_pkg;

    localparam logic [4:0] OpKey = 5'd0;  // key expand
    localparam logic [4:0] OpEnc = 5'd1;  // encrypt
    localparam logic [4:0] OpDec = 5'd2;  // decrypt

    localparam logic [31:0] ErrBadOpcode = 32'hEEEE_0001;
    localparam logic [31:0] ErrTimeout   = 32'hEEEE_0002;

    localparam int unsigned KeyWords   = 8;  // 256-bit key payload
    localparam int unsigned BlockWords = 4;  // 128-bit block payload

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWait,
        StSend,
        StErr
    } state_e;

    function automatic logic opcode_valid(input logic [4:0] op);
        return (op == OpKey) || (op == OpEnc) || (op == OpDec);
    endfunction

    // Index of the final payload word for a given opcode.
    function automatic logic [2:0] last_payload_idx(input logic [4:0] op);
        return (op == OpKey) ? 3'(KeyWords - 1) : 3'(BlockWords - 1);
    endfunction

    // Word idx of a 128-bit result, idx 0 being the most significant word.
    function automatic logic [31:0] result_word(input logic [127:0] r, input logic [1:0] idx);
        return r[{~idx, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/aes_cmd_master.sv
// aes_cmd_master: bridges a 32-bit host command stream to a 256-bit AES core.
//   A header word selects the opcode, payload words are packed MSW-first into
//   aes_data_in, the command is issued to the core, and the 128-bit result is
//   streamed back to the host (or a single status/error word is returned).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   host_in_*           host command words (valid/ready)
//   host_out_*          response words (valid/ready, last marks final word)
//   aes_input_*         command handshake to the AES core, with aes_opcode/aes_data_in
//   aes_output_*        result handshake from the AES core, with aes_data_out
//   busy                high whenever a command is in progress
module aes_cmd_master
    import aes_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         host_in_valid,
    output logic         host_in_ready,
    input  logic [31:0]  host_in_data,
    output logic         host_out_valid,
    input  logic         host_out_ready,
    output logic [31:0]  host_out_data,
    output logic         host_out_last,
    output logic         aes_input_valid,
    input  logic         aes_input_ready,
    output logic [4:0]   aes_opcode,
    output logic [255:0] aes_data_in,
    input  logic [127:0] aes_data_out,
    input  logic         aes_output_valid,
    output logic         aes_output_ready,
    output logic         busy
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    state_e              state_q;
    logic [2:0]          word_cnt_q;  // payload index in LOAD, response index in SEND
    logic [TimerW-1:0]   timer_q;
    logic [127:0]        result_q;
    logic [2:0]          next_cnt;

    assign next_cnt = word_cnt_q + 3'd1;

    // All outputs are registered and updated together with the state so that
    // every output is zero while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            word_cnt_q       <= '0;
            timer_q          <= '0;
            result_q         <= '0;
            host_in_ready    <= 1'b0;
            host_out_valid   <= 1'b0;
            host_out_data    <= '0;
            host_out_last    <= 1'b0;
            aes_input_valid  <= 1'b0;
            aes_opcode       <= '0;
            aes_data_in      <= '0;
            aes_output_ready <= 1'b0;
            busy             <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    host_in_ready <= 1'b1;
                    if (host_in_valid && host_in_ready) begin
                        aes_opcode  <= host_in_data[4:0];
                        word_cnt_q  <= '0;
                        // Clear so block ops see zeros in [127:0] after a key expand.
                        aes_data_in <= '0;
                        busy        <= 1'b1;
                        if (opcode_valid(host_in_data[4:0])) begin
                            state_q <= StLoad;
                        end else begin
                            state_q        <= StErr;
                            host_in_ready  <= 1'b0;
                            host_out_valid <= 1'b1;
                            host_out_data  <= ErrBadOpcode;
                            host_out_last  <= 1'b1;
                        end
                    end
                end

                StLoad: begin
                    if (host_in_valid && host_in_ready) begin
                        // Word 0 lands in [255:224], later words fill downwards.
                        aes_data_in[{~word_cnt_q, 5'd0} +: 32] <= host_in_data;
                        word_cnt_q <= next_cnt;
                        if (word_cnt_q == last_payload_idx(aes_opcode)) begin
                            state_q         <= StIssue;
                            host_in_ready   <= 1'b0;
                            aes_input_valid <= 1'b1;
                        end
                    end
                end

                StIssue: begin
                    if (aes_input_valid && aes_input_ready) begin
                        state_q          <= StWait;
                        aes_input_valid  <= 1'b0;
                        aes_output_ready <= 1'b1;
                        timer_q          <= '0;
                    end
                end

                StWait: begin
                    // A result arriving on the timeout cycle still wins.
                    if (aes_output_valid && aes_output_ready) begin
                        state_q          <= StSend;
                        result_q         <= aes_data_out;
                        aes_output_ready <= 1'b0;
                        word_cnt_q       <= '0;
                        host_out_valid   <= 1'b1;
                        if (aes_opcode == OpKey) begin
                            host_out_data <= '0;
                            host_out_last <= 1'b1;
                        end else begin
                            host_out_data <= aes_data_out[127:96];
                            host_out_last <= 1'b0;
                        end
                    end else if (timer_q == TimerLast) begin
                        state_q          <= StErr;
                        aes_output_ready <= 1'b0;
                        host_out_valid   <= 1'b1;
                        host_out_data    <= ErrTimeout;
                        host_out_last    <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end

                StSend: begin
                    if (host_out_valid && host_out_ready) begin
                        if (host_out_last) begin
                            state_q        <= StIdle;
                            host_out_valid <= 1'b0;
                            host_out_data  <= '0;
                            host_out_last  <= 1'b0;
                            busy           <= 1'b0;
                            host_in_ready  <= 1'b1;
                        end else begin
                            word_cnt_q    <= next_cnt;
                            host_out_data <= result_word(result_q, next_cnt[1:0]);
                            host_out_last <= (next_cnt[1:0] == 2'd3);
                        end
                    end
                end

                StErr: begin
                    if (host_out_valid && host_out_ready) begin
                        state_q        <= StIdle;
                        host_out_valid <= 1'b0;
                        host_out_data  <= '0;
                        host_out_last  <= 1'b0;
                        busy           <= 1'b0;
                        host_in_ready  <= 1'b1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cmd_master.sv
// tb_aes_cmd_master: directed self-checking bench for aes_cmd_master with a
// short timeout so the timeout path can be exercised quickly.
module tb_aes_cmd_master;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         host_in_valid = 1'b0;
    logic         host_in_ready;
    logic [31:0]  host_in_data = '0;
    logic         host_out_valid;
    logic         host_out_ready = 1'b0;
    logic [31:0]  host_out_data;
    logic         host_out_last;
    logic         aes_input_valid;
    logic         aes_input_ready = 1'b0;
    logic [4:0]   aes_opcode;
    logic [255:0] aes_data_in;
    logic [127:0] aes_data_out = '0;
    logic         aes_output_valid = 1'b0;
    logic         aes_output_ready;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rsp_data [8];
    logic [7:0]  rsp_last_mask;
    int          rsp_n;
    bit          rsp_done;

    localparam logic [127:0] EncPt = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] EncCt = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;

    aes_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .host_in_valid    (host_in_valid),
        .host_in_ready    (host_in_ready),
        .host_in_data     (host_in_data),
        .host_out_valid   (host_out_valid),
        .host_out_ready   (host_out_ready),
        .host_out_data    (host_out_data),
        .host_out_last    (host_out_last),
        .aes_input_valid  (aes_input_valid),
        .aes_input_ready  (aes_input_ready),
        .aes_opcode       (aes_opcode),
        .aes_data_in      (aes_data_in),
        .aes_data_out     (aes_data_out),
        .aes_output_valid (aes_output_valid),
        .aes_output_ready (aes_output_ready),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic send_word(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        host_in_valid = 1'b1;
        host_in_data  = w;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (host_in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        host_in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [4:0] op, input logic [127:0] pt, output bit ok);
        bit k;
        send_word({27'd0, op}, ok);
        for (int i = 0; i < 4; i++) begin
            send_word(pt[127 - 32*i -: 32], k);
            ok &= k;
        end
    endtask

    task automatic aes_issue(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (aes_input_valid) begin
                aes_input_ready = 1'b1;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        aes_input_ready = 1'b0;
    endtask

    task automatic aes_result(input logic [127:0] r, output bit ok);
        ok = 1'b0;
        aes_output_valid = 1'b1;
        aes_data_out     = r;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (aes_output_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        aes_output_valid = 1'b0;
    endtask

    task automatic collect(input int budget);
        rsp_n = 0;
        rsp_last_mask = '0;
        rsp_done = 1'b0;
        host_out_ready = 1'b1;
        for (int c = 0; c < budget && !rsp_done; c++) begin
            if (host_out_valid) begin
                if (rsp_n < 8) begin
                    rsp_data[rsp_n]      = host_out_data;
                    rsp_last_mask[rsp_n] = host_out_last;
                end
                rsp_n++;
                if (host_out_last) rsp_done = 1'b1;
            end
            @(posedge clk); #1;
        end
        host_out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({host_in_ready, host_out_valid, host_out_last, aes_input_valid,
             aes_output_ready, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000", {host_in_ready, host_out_valid,
                     host_out_last, aes_input_valid, aes_output_ready, busy});
        end
        n_checks++;
        if (host_out_data !== 32'h0 || aes_opcode !== 5'h0 || aes_data_in !== 256'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h required zeros", host_out_data, aes_opcode,
                     aes_data_in);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (host_in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b busy=%b required ready=1 busy=0",
                     host_in_ready, busy);
        end
    endtask

    task automatic test_encrypt();
        bit ok, k;
        send_block(5'd1, EncPt, ok);
        n_checks++;
        if (ok !== 1'b1 || aes_input_valid !== 1'b1 || aes_opcode !== 5'd1) begin
            n_fail++;
            $display("FAIL enc_issue: got ok=%b valid=%b op=%0d required 1/1/1", ok,
                     aes_input_valid, aes_opcode);
        end
        n_checks++;
        if (aes_data_in !== {EncPt, 128'h0}) begin
            n_fail++;
            $display("FAIL enc_operand: got %h required %h", aes_data_in, {EncPt, 128'h0});
        end
        aes_issue(ok);
        n_checks++;
        if (ok !== 1'b1 || aes_output_ready !== 1'b1 || host_in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL enc_wait: got ok=%b ordy=%b irdy=%b busy=%b required 1/1/0/1", ok,
                     aes_output_ready, host_in_ready, busy);
        end
        aes_result(EncCt, k);
        collect(20);
        n_checks++;
        if (k !== 1'b1 || rsp_done !== 1'b1 || rsp_n !== 4 || rsp_last_mask !== 8'b0000_1000) begin
            n_fail++;
            $display("FAIL enc_rsp_shape: got ok=%b done=%b n=%0d last=%b required 1/1/4/00001000",
                     k, rsp_done, rsp_n, rsp_last_mask);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rsp_data[i] !== EncCt[127 - 32*i -: 32]) begin
                n_fail++;
                $display("FAIL enc_word%0d: got %h required %h", i, rsp_data[i],
                         EncCt[127 - 32*i -: 32]);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || host_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL enc_idle: got busy=%b ready=%b required 0/1", busy, host_in_ready);
        end
    endtask

    task automatic test_key_expand();
        bit ok, k;
        logic [255:0] key;
        key = 256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;
        send_word(32'h0, ok);
        for (int i = 0; i < 8; i++) begin
            send_word(key[255 - 32*i -: 32], k);
            ok &= k;
        end
        n_checks++;
        if (ok !== 1'b1 || aes_input_valid !== 1'b1 || aes_opcode !== 5'd0 || aes_data_in !== key) begin
            n_fail++;
            $display("FAIL key_operand: got ok=%b valid=%b op=%0d data=%h required 1/1/0/%h", ok,
                     aes_input_valid, aes_opcode, aes_data_in, key);
        end
        aes_issue(ok);
        aes_result(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, k);
        collect(20);
        n_checks++;
        if (rsp_done !== 1'b1 || rsp_n !== 1 || rsp_data[0] !== 32'h0 || rsp_last_mask !== 8'b1) begin
            n_fail++;
            $display("FAIL key_rsp: got done=%b n=%0d word=%h last=%b required 1/1/00000000/1",
                     rsp_done, rsp_n, rsp_data[0], rsp_last_mask);
        end
    endtask

    task automatic test_bad_opcode();
        bit ok;
        send_word(32'h5, ok);
        n_checks++;
        if (ok !== 1'b1 || aes_input_valid !== 1'b0 || host_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_op_state: got ok=%b aes_valid=%b ready=%b required 1/0/0", ok,
                     aes_input_valid, host_in_ready);
        end
        collect(20);
        n_checks++;
        if (rsp_done !== 1'b1 || rsp_n !== 1 || rsp_data[0] !== 32'hEEEE_0001 ||
            rsp_last_mask !== 8'b1) begin
            n_fail++;
            $display("FAIL bad_op_rsp: got n=%0d word=%h last=%b required 1/eeee0001/1", rsp_n,
                     rsp_data[0], rsp_last_mask);
        end
        n_checks++;
        if (busy !== 1'b0 || aes_input_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_op_idle: got busy=%b aes_valid=%b required 0/0", busy,
                     aes_input_valid);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc;
        send_block(5'd1, EncPt, ok);
        aes_issue(ok);
        cyc = 0;
        for (int c = 1; c <= 40 && cyc == 0; c++) begin
            @(posedge clk); #1;
            if (host_out_valid) cyc = c;
        end
        n_checks++;
        if (cyc !== 16) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles required 16", cyc);
        end
        collect(20);
        n_checks++;
        if (rsp_n !== 1 || rsp_data[0] !== 32'hEEEE_0002 || rsp_last_mask !== 8'b1) begin
            n_fail++;
            $display("FAIL timeout_rsp: got n=%0d word=%h last=%b required 1/eeee0002/1", rsp_n,
                     rsp_data[0], rsp_last_mask);
        end
    endtask

    task automatic test_backpressure();
        bit ok, k, stable, stall_ok, prev_stall, done, prev_last;
        logic [31:0] prev_data;
        logic [31:0] got [4];
        logic [3:0]  lmask;
        int n;
        send_block(5'd2, EncCt, ok);
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (aes_input_valid !== 1'b1 || aes_opcode !== 5'd2 || aes_data_in !== {EncCt, 128'h0})
                stable = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (ok !== 1'b1 || stable !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_issue_stable: got ok=%b stable=%b required 1/1", ok, stable);
        end
        aes_issue(ok);
        aes_result(EncPt, k);
        n = 0; lmask = '0; done = 1'b0; stall_ok = 1'b1; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            host_out_ready = (c % 3 == 2);
            if (prev_stall && (host_out_valid !== 1'b1 || host_out_data !== prev_data ||
                               host_out_last !== prev_last))
                stall_ok = 1'b0;
            if (host_out_valid && host_out_ready) begin
                if (n < 4) begin
                    got[n]   = host_out_data;
                    lmask[n] = host_out_last;
                end
                n++;
                if (host_out_last) done = 1'b1;
            end
            prev_stall = host_out_valid && !host_out_ready;
            prev_data  = host_out_data;
            prev_last  = host_out_last;
            @(posedge clk); #1;
        end
        host_out_ready = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || k !== 1'b1 || stall_ok !== 1'b1 || n !== 4 || lmask !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_rsp_shape: got ok=%b/%b stable=%b n=%0d last=%b required 1/1/1/4/1000",
                     ok, k, stall_ok, n, lmask);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got[i] !== EncPt[127 - 32*i -: 32]) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h required %h", i, got[i], EncPt[127 - 32*i -: 32]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        send_block(5'd1, EncPt, ok);
        aes_issue(ok);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({host_in_ready, host_out_valid, host_out_last, aes_input_valid, aes_output_ready,
             busy} !== 6'b0 || host_out_data !== 32'h0 || aes_opcode !== 5'h0 ||
            aes_data_in !== 256'h0) begin
            n_fail++;
            $display("FAIL midwait_reset: got ctrl=%b data=%h op=%0d operand=%h required zeros",
                     {host_in_ready, host_out_valid, host_out_last, aes_input_valid,
                      aes_output_ready, busy}, host_out_data, aes_opcode, aes_data_in);
        end
        rst = 1'b0;
        // A late result from the aborted command must be ignored.
        aes_output_valid = 1'b1;
        aes_data_out     = EncCt;
        @(posedge clk); #1;
        aes_output_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (host_in_ready !== 1'b1 || host_out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_silent: got ready=%b out_valid=%b busy=%b required 1/0/0",
                     host_in_ready, host_out_valid, busy);
        end
        test_encrypt();
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_key_expand();
        test_bad_opcode();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
